// File: rtl/regfile_cfg_param.sv
// regfile_cfg_param: generic engine register file (CTRL, W1C STATUS, CFG, STAT) with registered reads.
// Define REGFILE_CFG_SHADOW_EN to buffer CFG writes in shadow registers until COMMIT or START.
module regfile_cfg_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 14,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 14'h100,
    parameter int N_CFG = 14,
    parameter int N_STAT = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          write_data,
    output logic [DATA_W-1:0]          read_data,
    output logic                       rd_valid,
    output logic [N_CFG*DATA_W-1:0]    cfg_o,
    input  logic [N_STAT*DATA_W-1:0]   stat_i,
    input  logic                       busy_i,
    input  logic                       done_i,
    output logic                       start_o,
    output logic                       irq_o
);
    localparam int W = 2 + N_CFG + N_STAT;

    logic [ADDR_W-1:0] off;
    logic hit, wr_hit, wr_ctrl, cfg_wr, start_req, start_ok, commit_req, irq_en;
    logic [2:0] status, w1c, set;
    logic [N_CFG-1:0][DATA_W-1:0] cfg_q, act;
    logic [DATA_W-1:0] rd_word;

    assign off = addr - BASE_ADDR;
    assign hit = (addr >= BASE_ADDR) && (off < ADDR_W'(W));
    assign wr_hit = wr_en & hit;
    assign wr_ctrl = wr_hit && off == '0;
    assign cfg_wr = wr_hit && off >= ADDR_W'(2) && off < ADDR_W'(2 + N_CFG);
    assign start_req = wr_ctrl & write_data[0];
    assign start_ok = start_req & ~busy_i;
    assign w1c = (wr_hit && off == ADDR_W'(1)) ? write_data[2:0] : 3'b0;
    assign set = {wr_hit && off >= ADDR_W'(2 + N_CFG), busy_i & (start_req | cfg_wr | commit_req), done_i};
    assign irq_o = irq_en & |status;
    assign cfg_o = act;

`ifdef REGFILE_CFG_SHADOW_EN
    logic commit_p;
    assign commit_req = wr_ctrl & write_data[1];
    // active only changes on an accepted commit or start, so it is stable while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_p <= 1'b0;
            act <= '0;
        end else begin
            commit_p <= commit_req & ~busy_i;
            if (commit_p | start_ok) act <= cfg_q;
        end
    end
`else
    assign commit_req = 1'b0;
    assign act = cfg_q;
`endif

    always_comb begin
        rd_word = '0;
        if (off == '0) rd_word[2] = irq_en;
        if (off == ADDR_W'(1)) rd_word[2:0] = status;
        for (int k = 0; k < N_CFG; k++)
            if (off == ADDR_W'(2 + k)) rd_word = cfg_q[k];
        for (int k = 0; k < N_STAT; k++)
            if (off == ADDR_W'(2 + N_CFG + k)) rd_word = stat_i[k*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= '0;
            status <= '0;
            irq_en <= 1'b0;
            start_o <= 1'b0;
            rd_valid <= 1'b0;
            read_data <= '0;
        end else begin
            for (int k = 0; k < N_CFG; k++)
                if (cfg_wr && !busy_i && off == ADDR_W'(2 + k)) cfg_q[k] <= write_data;
            status <= (status & ~w1c) | set;
            if (wr_ctrl) irq_en <= write_data[2];
            start_o <= start_ok;
            rd_valid <= rd_en;
            if (rd_en) read_data <= hit ? rd_word : '0;
        end
    end
endmodule

// File: tb/tb_regfile_cfg_param.sv
// tb_regfile_cfg_param: directed table, corner sequences and random traffic against a reference model.
module tb_regfile_cfg_param;
    localparam int DW = 16, AW = 14, NC = 14, NS = 3, W = 2 + NC + NS;

    logic clk = 0, rst_n = 0, wr_en = 0, rd_en = 0, busy_i = 0, done_i = 0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] write_data = '0, read_data;
    logic rd_valid, start_o, irq_o;
    logic [NC*DW-1:0] cfg_o;
    logic [NS*DW-1:0] stat_i = '0;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    regfile_cfg_param dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .write_data(write_data), .read_data(read_data), .rd_valid(rd_valid),
        .cfg_o(cfg_o), .stat_i(stat_i), .busy_i(busy_i), .done_i(done_i),
        .start_o(start_o), .irq_o(irq_o)
    );

    logic [DW-1:0] m_cfg[NC], m_act[NC], m_rd;
    logic [2:0] m_st;
    logic m_ien, m_start, m_commit, m_rv;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < NC; k++) begin
            m_cfg[k] = '0;
            m_act[k] = '0;
        end
        m_st = '0; m_ien = 0; m_start = 0; m_commit = 0; m_rv = 0; m_rd = '0;
    endtask

    function automatic logic [NC*DW-1:0] m_cfg_o();
        logic [NC*DW-1:0] r;
        for (int k = 0; k < NC; k++) begin
`ifdef REGFILE_CFG_SHADOW_EN
            r[k*DW +: DW] = m_act[k];
`else
            r[k*DW +: DW] = m_cfg[k];
`endif
        end
        return r;
    endfunction

    // Applies the architectural rules to the inputs the DUT saw at this edge.
    task automatic model_edge();
        int o = int'(addr) - 'h100;
        bit hit = o >= 0 && o < W;
        logic [2:0] set = 0, clr = 0;
        logic n_start = 0, n_commit = 0;
        if (rd_en) begin
            m_rd = '0;
            if (hit) begin
                if (o == 0) m_rd = {13'b0, m_ien, 2'b0};
                else if (o == 1) m_rd = {13'b0, m_st};
                else if (o < 2 + NC) m_rd = m_cfg[o-2];
                else m_rd = stat_i[(o-2-NC)*DW +: DW];
            end
        end
        m_rv = rd_en;
`ifdef REGFILE_CFG_SHADOW_EN
        if (m_commit || (wr_en && hit && o == 0 && write_data[0] && !busy_i))
            for (int k = 0; k < NC; k++) m_act[k] = m_cfg[k];
`endif
        if (wr_en && hit) begin
            if (o == 0) begin
                if (write_data[0]) begin
                    if (busy_i) set[1] = 1; else n_start = 1;
                end
`ifdef REGFILE_CFG_SHADOW_EN
                if (write_data[1]) begin
                    if (busy_i) set[1] = 1; else n_commit = 1;
                end
`endif
                m_ien = write_data[2];
            end else if (o == 1) clr = write_data[2:0];
            else if (o < 2 + NC) begin
                if (busy_i) set[1] = 1; else m_cfg[o-2] = write_data;
            end else set[2] = 1;
        end
        if (done_i) set[0] = 1;
        m_st = (m_st & ~clr) | set;
        m_start = n_start;
        m_commit = n_commit;
    endtask

    task automatic compare();
        chk("rd_valid", rd_valid, m_rv);
        chk("read_data", read_data, m_rd);
        chk("start_o", start_o, m_start);
        chk("irq_o", irq_o, m_ien && m_st != 0);
        chk("cfg_o", cfg_o, m_cfg_o());
    endtask

    task automatic step(input logic w, input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic b, input logic dn);
        wr_en = w; rd_en = r; addr = a; write_data = d; busy_i = b; done_i = dn;
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    typedef struct {
        bit wr, rd;
        bit [AW-1:0] a;
        bit [DW-1:0] d;
        bit busy, done;
        bit [DW-1:0] e_rd;
        bit e_rv, e_start, e_irq;
    } vec_t;
    vec_t tbl[28];

    initial begin
        tbl[0]  = '{1, 0, 14'h102, 16'hABCD, 0, 0, 16'h0000, 0, 0, 0};
        tbl[1]  = '{0, 1, 14'h102, 16'h0000, 0, 0, 16'hABCD, 1, 0, 0};
        tbl[2]  = '{1, 0, 14'h100, 16'h0001, 0, 0, 16'h0000, 0, 1, 0};
        tbl[3]  = '{0, 0, 14'h000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0};
        tbl[4]  = '{1, 0, 14'h100, 16'h0001, 1, 0, 16'h0000, 0, 0, 0};
        tbl[5]  = '{0, 1, 14'h101, 16'h0000, 0, 0, 16'h0002, 1, 0, 0};
        tbl[6]  = '{1, 0, 14'h101, 16'h0002, 0, 0, 16'h0000, 0, 0, 0};
        tbl[7]  = '{1, 0, 14'h100, 16'h0004, 0, 0, 16'h0000, 0, 0, 0};
        tbl[8]  = '{0, 0, 14'h000, 16'h0000, 0, 1, 16'h0000, 0, 0, 1};
        tbl[9]  = '{0, 1, 14'h101, 16'h0000, 0, 0, 16'h0001, 1, 0, 1};
        tbl[10] = '{1, 0, 14'h101, 16'h0001, 0, 1, 16'h0000, 0, 0, 1};
        tbl[11] = '{0, 1, 14'h101, 16'h0000, 0, 0, 16'h0001, 1, 0, 1};
        tbl[12] = '{1, 0, 14'h101, 16'h0001, 0, 0, 16'h0000, 0, 0, 0};
        tbl[13] = '{1, 0, 14'h110, 16'hFFFF, 0, 0, 16'h0000, 0, 0, 1};
        tbl[14] = '{0, 1, 14'h110, 16'h0000, 0, 0, 16'h1111, 1, 0, 1};
        tbl[15] = '{0, 1, 14'h0FF, 16'h0000, 0, 0, 16'h0000, 1, 0, 1};
        tbl[16] = '{0, 1, 14'h100, 16'h0000, 0, 0, 16'h0004, 1, 0, 1};
        tbl[17] = '{1, 0, 14'h101, 16'h0007, 0, 0, 16'h0000, 0, 0, 0};
        tbl[18] = '{1, 0, 14'h100, 16'h0000, 0, 0, 16'h0000, 0, 0, 0};
        tbl[19] = '{1, 1, 14'h103, 16'h1234, 0, 0, 16'h0000, 1, 0, 0};
        tbl[20] = '{0, 1, 14'h103, 16'h0000, 0, 0, 16'h1234, 1, 0, 0};
        tbl[21] = '{1, 0, 14'h103, 16'h5555, 1, 0, 16'h0000, 0, 0, 0};
        tbl[22] = '{0, 1, 14'h103, 16'h0000, 0, 0, 16'h1234, 1, 0, 0};
        tbl[23] = '{0, 1, 14'h101, 16'h0000, 0, 0, 16'h0002, 1, 0, 0};
        tbl[24] = '{1, 0, 14'h101, 16'h0007, 0, 0, 16'h0000, 0, 0, 0};
        tbl[25] = '{1, 0, 14'h100, 16'h0001, 0, 0, 16'h0000, 0, 1, 0};
        tbl[26] = '{1, 0, 14'h100, 16'h0001, 0, 0, 16'h0000, 0, 1, 0};
        tbl[27] = '{0, 0, 14'h000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0};

        m_reset();
        #12;
        compare();
        @(negedge clk) rst_n = 1;
        for (int o = 0; o < W; o++) begin
            step(0, 1, AW'('h100 + o), '0, 0, 0);
            chk($sformatf("sweep%0d_rdata", o), read_data, 0);
            chk($sformatf("sweep%0d_rv", o), rd_valid, 1);
        end
        step(0, 0, '0, '0, 0, 0);

        stat_i = 48'h3333_2222_1111;
        for (int i = 0; i < 28; i++) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d, tbl[i].busy, tbl[i].done);
            if (tbl[i].e_rv) chk($sformatf("tbl%0d_rdata", i), read_data, tbl[i].e_rd);
            chk($sformatf("tbl%0d_rv", i), rd_valid, tbl[i].e_rv);
            chk($sformatf("tbl%0d_start", i), start_o, tbl[i].e_start);
            chk($sformatf("tbl%0d_irq", i), irq_o, tbl[i].e_irq);
        end
        chk("cfg0_active", cfg_o[15:0], 16'hABCD);

`ifdef REGFILE_CFG_SHADOW_EN
        step(1, 0, 14'h104, 16'hBEEF, 0, 0);
        chk("cfg2_before_commit", cfg_o[47:32], 16'h0000);
        step(1, 0, 14'h100, 16'h0002, 0, 0);
        step(0, 0, '0, '0, 0, 0);
        chk("cfg2_after_commit", cfg_o[47:32], 16'hBEEF);
        step(1, 0, 14'h104, 16'h1234, 0, 0);
        step(1, 0, 14'h100, 16'h0002, 1, 0);
        step(0, 0, '0, '0, 0, 0);
        step(0, 1, 14'h101, '0, 0, 0);
        chk("cfg2_commit_busy", cfg_o[47:32], 16'hBEEF);
        chk("status_commit_busy", read_data, 16'h0002);
        step(1, 0, 14'h101, 16'h0007, 0, 0);
`else
        step(1, 0, 14'h104, 16'hBEEF, 0, 0);
        chk("cfg2_direct", cfg_o[47:32], 16'hBEEF);
`endif

        // Reset while a start pulse, a read result and an interrupt are all live.
        step(1, 0, 14'h100, 16'h0004, 0, 1);
        step(1, 1, 14'h100, 16'h0005, 0, 0);
        chk("pre_rst_start", start_o, 1);
        chk("pre_rst_rdata", read_data, 16'h0004);
        wr_en = 1; rd_en = 0; addr = 14'h102; write_data = 16'h7777;
        #2 rst_n = 0;
        #1;
        m_reset();
        chk("rst_start", start_o, 0);
        chk("rst_rv", rd_valid, 0);
        chk("rst_rdata", read_data, 0);
        chk("rst_irq", irq_o, 0);
        chk("rst_cfg", cfg_o, 0);
        @(posedge clk);
        #1;
        chk("rst_hold_cfg", cfg_o, 0);
        chk("rst_hold_start", start_o, 0);
        wr_en = 0;
        @(negedge clk) rst_n = 1;
        for (int i = 0; i < 3; i++) step(0, 0, '0, '0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            stat_i = 48'({$urandom(), $urandom()});
            step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 5, AW'($urandom_range('h114, 'hFE)),
                 DW'($urandom()), $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
